// File: rtl/noc_pkg.sv
//------------------------------------------------------------------------------
// noc_pkg : shared NoC flit width, downstream buffer depth and flit type
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package noc_pkg;
  localparam int FLIT_W       = 16;
  localparam int IN_BUF_DEPTH = 5;

  typedef logic [FLIT_W-1:0] flit_t;
endpackage

`default_nettype wire

// File: rtl/noc_flit_fifo.sv
//------------------------------------------------------------------------------
// noc_flit_fifo : small circular flit buffer with head-of-queue read port
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // The owner never pushes when full nor pops when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/noc_output_port.sv
//------------------------------------------------------------------------------
// noc_output_port : credit-based NoC output port; NOC_OUT_STATS_EN adds flit_cnt_o
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module noc_output_port
  import noc_pkg::*;
#(
  parameter int WIDTH   = FLIT_W,
  parameter int DEPTH   = 2,
  parameter int CREDITS = IN_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [WIDTH-1:0]             data_o,
  output logic                         write_en_o,
  input  logic                         credit_i,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic                         error_o
`ifdef NOC_OUT_STATS_EN
  ,
  output logic [31:0]                  flit_cnt_o
`endif
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0]    credit_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             accept;
  logic             send;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] send_data;

  assign ready_o = !fifo_full;
  assign accept  = valid_i && !fifo_full;
  // An empty buffer lets the incoming flit go straight to the output register.
  assign send      = (credit_cnt != '0) && (!fifo_empty || accept);
  assign bypass    = send && fifo_empty;
  assign push      = accept && !bypass;
  assign pop       = send && !fifo_empty;
  assign send_data = fifo_empty ? data_i : fifo_head;

  noc_flit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_i),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CW'(CREDITS);
      error_o    <= 1'b0;
    end else if (send && !credit_i) begin
      credit_cnt <= credit_cnt - CW'(1);
    end else if (credit_i && !send) begin
      if (credit_cnt == CW'(CREDITS)) error_o <= 1'b1;
      else                            credit_cnt <= credit_cnt + CW'(1);
    end
  end

  assign credit_cnt_o = credit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_o <= 1'b0;
      data_o     <= '0;
    end else begin
      write_en_o <= send;
      if (send) data_o <= send_data;
    end
  end

`ifdef NOC_OUT_STATS_EN
  logic [31:0] flit_cnt;

  always_ff @(posedge clk) begin
    if (rst)             flit_cnt <= '0;
    else if (write_en_o) flit_cnt <= flit_cnt + 32'd1;
  end

  assign flit_cnt_o = flit_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_output_port.sv
//------------------------------------------------------------------------------
// tb_noc_output_port : vector table plus randomized run against a queue model
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_noc_output_port;

  localparam int DEPTH   = 2;
  localparam int CREDITS = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        credit_i = 1'b0;
  logic        ready_o;
  logic [15:0] data_o;
  logic        write_en_o;
  logic [2:0]  credit_cnt_o;
  logic        error_o;
`ifdef NOC_OUT_STATS_EN
  logic [31:0] flit_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  noc_output_port #(
    .WIDTH   (16),
    .DEPTH   (DEPTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .write_en_o   (write_en_o),
    .credit_i     (credit_i),
    .credit_cnt_o (credit_cnt_o),
    .error_o      (error_o)
`ifdef NOC_OUT_STATS_EN
    ,
    .flit_cnt_o   (flit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          valid;
    logic [15:0] data;
    bit          credit;
    bit          we;
    logic [15:0] dout;
    bit          rdy;
    int          cnt;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit v, input logic [15:0] d, input bit c,
                     input bit we, input logic [15:0] dout, input bit rdy,
                     input int cnt, input bit err);
    vecs.push_back('{r, v, d, c, we, dout, rdy, cnt, err});
  endtask

  // Behavioural model state for the randomized run
  logic [15:0] mq[$];
  int          mcred;
  bit          merr;
  bit          mwe;
  logic [15:0] mdata;
  int          sent_model;
  int          sent_dut;
  int          tot_we;

  initial begin
    // reset held two cycles; credit during reset must not count
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 1, 5, 0);
    // single flit, one-cycle latency, credit consumed
    add(0, 1, 16'hA5A5, 0, 1, 16'hA5A5, 1, 4, 0);
    add(0, 0, 16'h0000, 0, 0, 16'hA5A5, 1, 4, 0);
    // credit return, then overflow (sticky, count saturated)
    add(0, 0, 16'h0000, 1, 0, 16'hA5A5, 1, 5, 0);
    add(0, 0, 16'h0000, 1, 0, 16'hA5A5, 1, 5, 1);
    add(0, 0, 16'h0000, 0, 0, 16'hA5A5, 1, 5, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0);
    // send and credit together at count 3 leave it at 3
    add(0, 1, 16'h0011, 0, 1, 16'h0011, 1, 4, 0);
    add(0, 1, 16'h0022, 0, 1, 16'h0022, 1, 3, 0);
    add(0, 1, 16'h0033, 1, 1, 16'h0033, 1, 3, 0);
    add(0, 0, 16'h0000, 0, 0, 16'h0033, 1, 3, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0);
    // credit exhaustion with flits 1..8
    add(0, 1, 16'd1, 0, 1, 16'd1, 1, 4, 0);
    add(0, 1, 16'd2, 0, 1, 16'd2, 1, 3, 0);
    add(0, 1, 16'd3, 0, 1, 16'd3, 1, 2, 0);
    add(0, 1, 16'd4, 0, 1, 16'd4, 1, 1, 0);
    add(0, 1, 16'd5, 0, 1, 16'd5, 1, 0, 0);
    add(0, 1, 16'd6, 0, 0, 16'd5, 1, 0, 0);
    add(0, 1, 16'd7, 0, 0, 16'd5, 0, 0, 0);
    add(0, 1, 16'd8, 0, 0, 16'd5, 0, 0, 0);
    // one credit pulse releases flit 6 two cycles later
    add(0, 1, 16'd8, 1, 0, 16'd5, 0, 1, 0);
    add(0, 1, 16'd8, 0, 1, 16'd6, 1, 0, 0);
    add(0, 1, 16'd8, 0, 0, 16'd6, 0, 0, 0);
    add(0, 0, 16'd0, 1, 0, 16'd6, 0, 1, 0);
    add(0, 0, 16'd0, 0, 1, 16'd7, 1, 0, 0);
    // reset mid-operation drops flit 8
    add(1, 0, 16'd0, 0, 0, 16'd0, 1, 5, 0);
    add(0, 0, 16'd0, 0, 0, 16'd0, 1, 5, 0);

    tot_we = 0;
    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      valid_i  = vecs[i].valid;
      data_i   = vecs[i].data;
      credit_i = vecs[i].credit;
      tick();
      if (vecs[i].rst) tot_we = 0;
      chk($sformatf("row%0d_write_en", i), 32'(write_en_o), 32'(vecs[i].we));
      chk($sformatf("row%0d_data", i), 32'(data_o), 32'(vecs[i].dout));
      chk($sformatf("row%0d_ready", i), 32'(ready_o), 32'(vecs[i].rdy));
      chk($sformatf("row%0d_credit_cnt", i), 32'(credit_cnt_o), 32'(vecs[i].cnt));
      chk($sformatf("row%0d_error", i), 32'(error_o), 32'(vecs[i].err));
`ifdef NOC_OUT_STATS_EN
      chk($sformatf("row%0d_flit_cnt", i), flit_cnt_o, 32'(tot_we));
`endif
      if (vecs[i].we) tot_we++;
    end

    // randomized run: model keeps a queue of buffered flits and a credit count
    rst = 1'b1; valid_i = 1'b0; credit_i = 1'b0;
    tick();
    rst = 1'b0;
    mq.delete();
    mcred = CREDITS; merr = 0; mwe = 0; mdata = '0;
    sent_model = 0; sent_dut = 0; tot_we = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      bit          v;
      bit          c;
      bit          snd;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = 16'($urandom);
      c = ($urandom_range(0, 2) == 0) && (mcred < CREDITS);
      if (v && (mq.size() < DEPTH)) mq.push_back(d);
      snd = (mq.size() > 0) && (mcred > 0);
      if (snd) begin
        mdata = mq.pop_front();
        sent_model++;
      end
      mwe = snd;
      if (snd && !c) mcred--;
      else if (c && !snd) begin
        if (mcred == CREDITS) merr = 1;
        else mcred++;
      end
      valid_i = v; data_i = d; credit_i = c;
      tick();
      chk($sformatf("rnd%0d_write_en", cyc), 32'(write_en_o), 32'(mwe));
      chk($sformatf("rnd%0d_data", cyc), 32'(data_o), 32'(mdata));
      chk($sformatf("rnd%0d_ready", cyc), 32'(ready_o), 32'(mq.size() < DEPTH));
      chk($sformatf("rnd%0d_credit_cnt", cyc), 32'(credit_cnt_o), 32'(mcred));
      chk($sformatf("rnd%0d_error", cyc), 32'(error_o), 32'(merr));
`ifdef NOC_OUT_STATS_EN
      chk($sformatf("rnd%0d_flit_cnt", cyc), flit_cnt_o, 32'(tot_we));
`endif
      if (write_en_o) sent_dut++;
      if (mwe) tot_we++;
    end
    valid_i = 1'b0; credit_i = 1'b0;
    chk("rnd_sent_total", 32'(sent_dut), 32'(sent_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/noc_output_port.md
NOC_OUTPUT_PORT -- requirements
Module: noc_output_port

Interface
REQ-001 Parameter WIDTH, default 16, flit width in bits.
REQ-002 Parameter DEPTH, default 2, local flit buffer entries (DEPTH >= 1).
REQ-003 Parameter CREDITS, default 5, downstream input-port buffer depth.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_i  input  WIDTH  flit from crossbar.
REQ-007 valid_i  input  1  crossbar offers data_i this cycle.
REQ-008 ready_o  output  1  port accepts a flit this cycle.
REQ-009 data_o  output  WIDTH  flit to downstream input port data_i.
REQ-010 write_en_o  output  1  drives downstream write_en; one cycle per flit.
REQ-011 credit_i  input  1  one-cycle pulse, asserted when the downstream port shifts a flit out.
REQ-012 credit_cnt_o  output  $clog2(CREDITS+1)  current free downstream slots.
REQ-013 error_o  output  1  sticky credit-overflow flag.

Function
REQ-014 Accept: a flit SHALL be written to the local FIFO when valid_i && ready_o.
REQ-015 ready_o SHALL equal !full and SHALL be derived from registered occupancy only, with no combinational path from valid_i.
REQ-016 Send condition: FIFO non-empty && credit_cnt > 0; when true, the head flit SHALL be popped.
REQ-017 data_o and write_en_o SHALL be registered; a flit popped in cycle N SHALL appear with write_en_o=1 in cycle N+1.
REQ-018 Minimum latency, accept to write_en_o, SHALL be 1 cycle: an empty FIFO with credits available sends a flit accepted in cycle N during cycle N+1.
REQ-019 write_en_o SHALL be 0 in any cycle following a cycle with no send; data_o SHALL hold its last value.
REQ-020 Credit update: credit_cnt_next = credit_cnt - send + credit_i.
REQ-021 Simultaneous send and credit_i SHALL leave credit_cnt unchanged.
REQ-022 credit_i while credit_cnt == CREDITS and no send SHALL saturate credit_cnt at CREDITS and set error_o until reset.
REQ-023 credit_cnt == 0 SHALL stall sending; the FIFO SHALL keep accepting until full.
REQ-024 Simultaneous accept and pop on a full FIFO SHALL NOT occur, because ready_o=0; on a non-full FIFO, simultaneous accept and pop SHALL leave occupancy unchanged.
REQ-025 Flits SHALL leave in arrival order, with none dropped or duplicated.

Reset
REQ-026 On rst=1 at a clock edge: FIFO emptied, credit_cnt=CREDITS, write_en_o=0, data_o=0, error_o=0, ready_o=1 in the following cycle.
REQ-027 Reset mid-operation SHALL discard buffered flits; credit_i pulses arriving while rst=1 SHALL be ignored.

Configuration
REQ-028 Macro NOC_OUT_STATS_EN defined: add output flit_cnt_o (32 bits).
REQ-029 flit_cnt_o SHALL be reset to 0, increment on each write_en_o=1 cycle, and wrap modulo 2^32.
REQ-030 Macro NOC_OUT_STATS_EN undefined: flit_cnt_o port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package noc_pkg SHALL hold FLIT_W=16, IN_BUF_DEPTH=5 (the CREDITS default), and typedef flit_t.
REQ-032 The local buffer SHALL be a sub-module noc_flit_fifo (parameterised WIDTH, DEPTH; push, pop, full, empty, head data); credit logic and output registers SHALL reside in noc_output_port.

Verification
REQ-033 Reset: assert rst for 2 cycles -> write_en_o=0, data_o=0, ready_o=1, credit_cnt_o=5, error_o=0.
REQ-034 Single flit: valid_i=1, data_i=16'hA5A5 at cycle N -> write_en_o=1, data_o=16'hA5A5 at N+1; credit_cnt_o=4 at N+2.
REQ-035 Credit exhaustion: 8 back-to-back flits 1..8, no credit_i -> flits 1..5 sent on consecutive cycles; credit_cnt_o=0; ready_o drops after the FIFO holds 6,7; flit 8 held off.
REQ-036 Credit return: from REQ-035, one credit_i pulse at cycle M -> flit 6 driven with write_en_o=1 at M+2; credit_cnt_o returns to 0.
REQ-037 Simultaneous events: credit_i and send in the same cycle with credit_cnt=3 -> credit_cnt stays 3; order preserved across 20 random flits against a scoreboard.
REQ-038 Overflow: idle port, credit_cnt=5, credit_i pulse -> error_o=1 next cycle and held; credit_cnt_o stays 5; with NOC_OUT_STATS_EN defined, flit_cnt_o equals the total write_en_o count.
